// File: rtl/cmp_pkg.sv
// Shared constants for the magnitude comparator: result encoding and width limit.
package cmp_pkg;

    localparam logic [1:0] CMP_EQ = 2'b00;
    localparam logic [1:0] CMP_LT = 2'b01;
    localparam logic [1:0] CMP_GT = 2'b10;

    localparam int MAX_WIDTH = 32;

    // Collapse the cascade's final lt/gt flags into a single result code.
    function automatic logic [1:0] cmp_encode(input logic lt, input logic gt);
        if (lt)
            return CMP_LT;
        else if (gt)
            return CMP_GT;
        else
            return CMP_EQ;
    endfunction

endpackage

// File: rtl/cmp_bit_cell.sv
// One bit of an MSB-first compare chain: a decision made by a more significant
// bit passes straight through, otherwise this bit decides if a and b differ.
module cmp_bit_cell #(
    parameter bit INVERT = 1'b0
) (
    input  logic a,
    input  logic b,
    input  logic lt_in,
    input  logic gt_in,
    output logic lt_out,
    output logic gt_out
);

    logic ai;
    logic bi;
    logic decided;

    // Inverting both bits makes a set sign bit rank below a clear one.
    assign ai      = a ^ INVERT;
    assign bi      = b ^ INVERT;
    assign decided = lt_in | gt_in;

    assign lt_out = lt_in | (~decided & ~ai &  bi);
    assign gt_out = gt_in | (~decided &  ai & ~bi);

endmodule

// File: rtl/two_bit_comparator.sv
// Registered WIDTH-bit comparator: a cascade of bit cells feeding one result
// register and a valid register, one compare per cycle.
module two_bit_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic             lesser,
    output logic             greater,
    output logic             equal,
    output logic             out_valid
);

    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("two_bit_comparator: WIDTH out of range");
    end

    logic [WIDTH:0] lt_c;
    logic [WIDTH:0] gt_c;
    logic [1:0]     res_c;
    logic [1:0]     res_p1;
    logic           vld_p1;

    assign lt_c[WIDTH] = 1'b0;
    assign gt_c[WIDTH] = 1'b0;

    for (genvar i = WIDTH - 1; i >= 0; i--) begin : g_cell
        cmp_bit_cell #(
            .INVERT (SIGNED && (i == WIDTH - 1))
        ) u_cell (
            .a      (a[i]),
            .b      (b[i]),
            .lt_in  (lt_c[i+1]),
            .gt_in  (gt_c[i+1]),
            .lt_out (lt_c[i]),
            .gt_out (gt_c[i])
        );
    end

    assign res_c = cmp_encode(lt_c[0], gt_c[0]);

    // ---- stage p1: result holds when no new sample arrives ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_p1 <= CMP_EQ;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid)
                res_p1 <= res_c;
        end
    end

    assign lesser    = (res_p1 == CMP_LT);
    assign greater   = (res_p1 == CMP_GT);
    assign equal     = (res_p1 == CMP_EQ);
    assign out_valid = vld_p1;

endmodule

// File: tb/tb_two_bit_comparator.sv
// Random and directed checks of four comparator configurations against an
// arithmetic reference model.
module tb_two_bit_comparator;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic iv    = 1'b0;

    always #5 clk = ~clk;

    logic [3:0] av [4];
    logic [3:0] bv [4];
    logic       lt [4];
    logic       gt [4];
    logic       eq [4];
    logic       ov [4];

    // instance 0: W=1 unsigned, 1: W=1 signed, 2: W=4 signed, 3: W=4 unsigned
    int wid [4] = '{1, 1, 4, 4};
    bit sgn [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

    logic [2:0] exp_r [4];   // {lesser, greater, equal}
    logic       exp_v;

    int n_chk  = 0;
    int n_pass = 0;

    two_bit_comparator #(.WIDTH(1), .SIGNED(1'b0)) u_w1u (
        .clk(clk), .rst_n(rst_n), .a(av[0][0:0]), .b(bv[0][0:0]), .in_valid(iv),
        .lesser(lt[0]), .greater(gt[0]), .equal(eq[0]), .out_valid(ov[0]));
    two_bit_comparator #(.WIDTH(1), .SIGNED(1'b1)) u_w1s (
        .clk(clk), .rst_n(rst_n), .a(av[1][0:0]), .b(bv[1][0:0]), .in_valid(iv),
        .lesser(lt[1]), .greater(gt[1]), .equal(eq[1]), .out_valid(ov[1]));
    two_bit_comparator #(.WIDTH(4), .SIGNED(1'b1)) u_w4s (
        .clk(clk), .rst_n(rst_n), .a(av[2]), .b(bv[2]), .in_valid(iv),
        .lesser(lt[2]), .greater(gt[2]), .equal(eq[2]), .out_valid(ov[2]));
    two_bit_comparator #(.WIDTH(4), .SIGNED(1'b0)) u_w4u (
        .clk(clk), .rst_n(rst_n), .a(av[3]), .b(bv[3]), .in_valid(iv),
        .lesser(lt[3]), .greater(gt[3]), .equal(eq[3]), .out_valid(ov[3]));

    function automatic int to_num(input int k, input logic [3:0] x);
        int v;
        v = int'(x) & ((1 << wid[k]) - 1);
        if (sgn[k] && v >= (1 << (wid[k] - 1)))
            v = v - (1 << wid[k]);
        return v;
    endfunction

    function automatic logic [2:0] ref_cmp(input int k);
        int x;
        int y;
        x = to_num(k, av[k]);
        y = to_num(k, bv[k]);
        if (x < y)      return 3'b100;
        else if (x > y) return 3'b010;
        else            return 3'b001;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        exp_v = 1'b0;
        for (int k = 0; k < 4; k++) exp_r[k] = 3'b001;
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 4; k++)
            check($sformatf("%s[%0d]", tag, k), {28'd0, ov[k], lt[k], gt[k], eq[k]},
                  {28'd0, exp_v, exp_r[k]});
    endtask

    // One clock edge, model update, then sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (iv)
                for (int k = 0; k < 4; k++) exp_r[k] = ref_cmp(k);
            exp_v = iv;
        end
        #1;
    endtask

    task automatic set_ab(input int k, input logic [3:0] x, input logic [3:0] y);
        av[k] = x;
        bv[k] = y;
    endtask

    initial begin
        for (int k = 0; k < 4; k++) set_ab(k, 4'd0, 4'd0);
        model_reset();

        // Asynchronous reset, held for three cycles
        #2 rst_n = 1'b0;
        #1 check_all("rst_async");
        for (int c = 0; c < 3; c++) begin
            tick();
            check_all("rst_hold");
        end
        rst_n = 1'b1;

        // First compare after release
        iv = 1'b1;
        set_ab(0, 4'd1, 4'd0);
        set_ab(1, 4'd1, 4'd0);
        set_ab(2, 4'b0011, 4'b1100);
        set_ab(3, 4'b0011, 4'b1100);
        tick();
        check_all("first");
        check("first_gt", {31'd0, gt[0]}, 32'd1);
        check("w1s_neg1_lt_0", {31'd0, lt[1]}, 32'd1);

        // Exhaustive 1-bit sweep, back to back
        for (int p = 0; p < 4; p++) begin
            logic [2:0] want [4];
            logic [1:0] pat;
            want = '{3'b001, 3'b100, 3'b010, 3'b001};
            pat  = 2'(p);
            set_ab(0, {3'd0, pat[1]}, {3'd0, pat[0]});
            set_ab(1, {3'd0, pat[1]}, {3'd0, pat[0]});
            tick();
            check_all("sweep");
            check($sformatf("sweep_const%0d", p), {28'd0, ov[0], lt[0], gt[0], eq[0]},
                  {28'd1, want[p]});
        end

        // Drop in_valid: results hold, out_valid goes low
        set_ab(0, 4'd0, 4'd1);
        tick();
        iv = 1'b0;
        set_ab(0, 4'd1, 4'd0);
        tick();
        check_all("hold");
        check("hold_ov", {31'd0, ov[0]}, 32'd0);
        check("hold_lt", {31'd0, lt[0]}, 32'd1);

        // 4-bit signed and unsigned corner cases
        iv = 1'b1;
        set_ab(2, 4'b1111, 4'b0001);
        set_ab(3, 4'b1000, 4'b0111);
        tick();
        check_all("w4_a");
        check("w4s_m1_lt_1", {31'd0, lt[2]}, 32'd1);
        check("w4u_8_gt_7", {31'd0, gt[3]}, 32'd1);
        set_ab(2, 4'b0111, 4'b1000);
        set_ab(3, 4'b1010, 4'b1010);
        tick();
        check_all("w4_b");
        check("w4s_7_gt_m8", {31'd0, gt[2]}, 32'd1);
        check("w4u_eq", {31'd0, eq[3]}, 32'd1);

        // Reset lands while a sample is pending: it must never be reported
        set_ab(3, 4'b0001, 4'b1111);
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1 check_all("midrst_async");
        tick();
        check_all("midrst_edge");
        rst_n = 1'b1;
        iv = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            check_all("midrst_after");
            check("midrst_ov", {31'd0, ov[3]}, 32'd0);
        end

        // Random traffic
        for (int c = 0; c < 300; c++) begin
            iv = ($urandom % 4) != 0;
            for (int k = 0; k < 4; k++) set_ab(k, 4'($urandom), 4'($urandom));
            if (($urandom % 4) == 0) bv[3] = av[3];
            tick();
            check_all("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/two_bit_comparator.md
TWO_BIT_COMPARATOR -- requirements
Module: two_bit_comparator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1, giving the operand width in bits (legal range 1..32).
REQ-002 The block SHALL have parameter SIGNED, default 0, where 1 selects two's-complement comparison.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port a, input, WIDTH bits: first operand.
REQ-007 The block SHALL have port b, input, WIDTH bits: second operand.
REQ-008 The block SHALL have port in_valid, input, 1 bit: when high, a and b are sampled on the rising clk edge.
REQ-009 The block SHALL have port lesser, output, 1 bit: registered, high when a < b.
REQ-010 The block SHALL have port greater, output, 1 bit: registered, high when a > b.
REQ-011 The block SHALL have port equal, output, 1 bit: registered, high when a == b.
REQ-012 The block SHALL have port out_valid, output, 1 bit: high for one cycle per completed compare.

Function
REQ-013 On a rising clk edge with in_valid=1, the block SHALL compare a and b and register the results.
REQ-014 The results SHALL appear on lesser/greater/equal one cycle after sampling, with out_valid=1 in that same cycle.
REQ-015 Exactly one of lesser, greater, equal SHALL be high after any completed compare (one-hot).
REQ-016 When in_valid=0, lesser/greater/equal SHALL hold their last values and out_valid SHALL be 0 in the following cycle.
REQ-017 With SIGNED=0, operands SHALL be treated as unsigned; with SIGNED=1, the MSB SHALL be the sign bit.
REQ-018 For WIDTH=1 with SIGNED=1, a=1 SHALL represent -1 and b=0 SHALL represent 0, so the result is lesser.
REQ-019 Back-to-back in_valid SHALL give one result per cycle, fully pipelined, with no stalls and no backpressure.
REQ-020 The comparison SHALL be MSB-first: the first differing bit position decides the result, and equal is asserted only if no bits differ.
REQ-021 The block SHALL contain no combinational path from a, b or in_valid to any output.

Reset
REQ-022 While rst_n=0, the block SHALL asynchronously force lesser=0, greater=0, out_valid=0 and equal=1.
REQ-023 The block SHALL release reset synchronously: the first compare is the first rising edge with rst_n=1 and in_valid=1.
REQ-024 If reset is asserted mid-operation, any in-flight result SHALL be discarded, and out_valid SHALL NOT be asserted for it after reset release.

Structure
REQ-025 The shared package cmp_pkg SHALL hold the result-encoding constants CMP_LT, CMP_EQ and CMP_GT (2-bit) and the MAX_WIDTH=32 limit.
REQ-026 The block SHALL use one sub-module, cmp_bit_cell: a 1-bit compare cell with cascade inputs and outputs (lt_in, gt_in, lt_out, gt_out).
REQ-027 The WIDTH cmp_bit_cell instances SHALL be chained MSB to LSB, with the MSB cell handling sign inversion when SIGNED=1.
REQ-028 The top level SHALL contain only the cascade, the result registers and the valid register.

Verification
REQ-029 With WIDTH=1, SIGNED=0 and in_valid=1, the bench SHALL drive {a,b}=00, 01, 10, 11 on successive cycles; the required outputs, one cycle later each, are equal, lesser, greater, equal, each with out_valid=1.
REQ-030 With rst_n=0 held for 3 cycles, the bench SHALL check lesser=0, greater=0, equal=1, out_valid=0; the first post-release compare of a=1, b=0 SHALL give greater=1.
REQ-031 After a=0, b=1 with in_valid=1, the bench SHALL drop in_valid and then check out_valid=0 while lesser=1 holds.
REQ-032 With WIDTH=4, SIGNED=1, the bench SHALL check a=4'b1111, b=4'b0001 -> lesser=1, and a=4'b0111, b=4'b1000 -> greater=1.
REQ-033 With WIDTH=4, SIGNED=0, the bench SHALL check a=4'b1000, b=4'b0111 -> greater=1, and a=b=4'b1010 -> equal=1.
REQ-034 The bench SHALL assert rst_n=0 in the cycle after a valid sample and check that out_valid is never asserted for that sample.
